// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants, ALU operation codes and fetch/decode FSM encoding.
// Used by instr_fetch_decode and alu_op_decoder.
package riscv_pkg;

   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   // ALU operation codes, identical to the codes the ALU consumes
   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_SLL  = 5'd2;
   localparam logic [4:0] OP_SLT  = 5'd3;
   localparam logic [4:0] OP_SLTU = 5'd4;
   localparam logic [4:0] OP_XOR  = 5'd5;
   localparam logic [4:0] OP_SRL  = 5'd6;
   localparam logic [4:0] OP_SRA  = 5'd7;
   localparam logic [4:0] OP_OR   = 5'd8;
   localparam logic [4:0] OP_AND  = 5'd9;
   localparam logic [4:0] OP_NOP  = 5'd31;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DECODE = 2'd2,
      ST_EXEC   = 2'd3
   } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational R-type decoder: maps {funct7, funct3, opcode} to an ALU operation
// code; anything outside the ten OP encodings yields OP_NOP and illegal.
module alu_op_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] i_funct7,
   input  logic [2:0] i_funct3,
   input  logic [6:0] i_opcode,
   output logic [4:0] o_operation,
   output logic       o_illegal
);

   logic [4:0] w_operation;

   always_comb begin
      w_operation = OP_NOP;
      if (i_opcode == OPC_OP && i_funct7 == F7_BASE) begin
         case (i_funct3)
            F3_ADD_SUB: w_operation = OP_ADD;
            F3_SLL:     w_operation = OP_SLL;
            F3_SLT:     w_operation = OP_SLT;
            F3_SLTU:    w_operation = OP_SLTU;
            F3_XOR:     w_operation = OP_XOR;
            F3_SRL_SRA: w_operation = OP_SRL;
            F3_OR:      w_operation = OP_OR;
            F3_AND:     w_operation = OP_AND;
            default:    w_operation = OP_NOP;
         endcase
      end else if (i_opcode == OPC_OP && i_funct7 == F7_ALT) begin
         case (i_funct3)
            F3_ADD_SUB: w_operation = OP_SUB;
            F3_SRL_SRA: w_operation = OP_SRA;
            default:    w_operation = OP_NOP;
         endcase
      end
   end

   assign o_operation = w_operation;
   assign o_illegal   = (w_operation == OP_NOP);

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode/execute FSM for RV32I R-type ALU instructions with req/ack fetch.
// Optional macro DECODE_ILLEGAL_TRAP_EN: illegal instructions stop the FSM with a sticky flag.
module instr_fetch_decode
   import riscv_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_halt,
   output logic                  o_imem_req,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   input  logic                  i_imem_ack,
   input  logic [31:0]           i_imem_rdata,
   output logic [4:0]            o_rs1,
   output logic [4:0]            o_rs2,
   output logic [4:0]            o_rw,
   output logic [4:0]            o_operation,
   output logic                  o_write,
   output logic                  o_busy,
   output logic                  o_illegal,
   output logic [31:0]           o_instr_count
);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [31:0]           r_ir;
   logic                  r_req;
   logic [4:0]            r_rs1;
   logic [4:0]            r_rs2;
   logic [4:0]            r_rw;
   logic [4:0]            r_operation;
   logic                  r_write;
   logic                  r_busy;
   logic                  r_illegal;
   logic [31:0]           r_count;

   logic [4:0]            w_operation;
   logic                  w_illegal;
   logic                  w_illegal_next;
   logic                  w_trap;

   alu_op_decoder u_alu_op_decoder (
      .i_funct7    (r_ir[31:25]),
      .i_funct3    (r_ir[14:12]),
      .i_opcode    (r_ir[6:0]),
      .o_operation (w_operation),
      .o_illegal   (w_illegal)
   );

`ifdef DECODE_ILLEGAL_TRAP_EN
   // Sticky flag; in EXEC it can only be set by the current instruction since start clears it
   assign w_illegal_next = r_illegal | w_illegal;
   assign w_trap         = r_illegal;
`else
   assign w_illegal_next = w_illegal;
   assign w_trap         = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_pc        <= RESET_PC;
         r_ir        <= '0;
         r_req       <= 1'b0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rw        <= '0;
         r_operation <= '0;
         r_write     <= 1'b0;
         r_busy      <= 1'b0;
         r_illegal   <= 1'b0;
         r_count     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_pc    <= RESET_PC;
                  r_req   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= ST_FETCH;
`ifdef DECODE_ILLEGAL_TRAP_EN
                  r_illegal <= 1'b0;
`endif
               end
            end
            ST_FETCH: begin
               if (r_req && i_imem_ack) begin
                  r_ir    <= i_imem_rdata;
                  r_req   <= 1'b0;
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_rs1       <= r_ir[19:15];
               r_rs2       <= r_ir[24:20];
               r_rw        <= r_ir[11:7];
               r_operation <= w_operation;
               r_illegal   <= w_illegal_next;
               r_write     <= !w_illegal && (r_ir[11:7] != 5'd0);
               r_state     <= ST_EXEC;
            end
            ST_EXEC: begin
               r_write <= 1'b0;
               if (!r_illegal) begin
                  r_count <= r_count + 32'd1;
               end
               if (!w_trap) begin
                  r_pc <= r_pc + ADDR_WIDTH'(4);
               end
               if (w_trap || i_halt) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_req   <= 1'b1;
                  r_state <= ST_FETCH;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_write <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_imem_req    = r_req;
   assign o_imem_addr   = r_pc;
   assign o_rs1         = r_rs1;
   assign o_rs2         = r_rs2;
   assign o_rw          = r_rw;
   assign o_operation   = r_operation;
   assign o_write       = r_write;
   assign o_busy        = r_busy;
   assign o_illegal     = r_illegal;
   assign o_instr_count = r_count;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: directed test-plan cases plus random
// instruction streams checked against a transaction-level reference model.
module tb_instr_fetch_decode;

   localparam int          AW     = 32;
   localparam logic [31:0] RST_PC = 32'h0;
`ifdef DECODE_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          halt  = 1'b0;
   logic          ack   = 1'b0;
   logic [31:0]   rdata = 32'h0;
   logic          o_imem_req;
   logic [AW-1:0] o_imem_addr;
   logic [4:0]    o_rs1, o_rs2, o_rw, o_operation;
   logic          o_write, o_busy, o_illegal;
   logic [31:0]   o_instr_count;

   int checks = 0;
   int errors = 0;
   int txn    = 0;

   // Reference model state, advanced once per retired transaction
   logic [31:0] m_pc, m_count;
   logic        m_illegal, m_busy;
   logic [4:0]  m_rs1, m_rs2, m_rw, m_op;

   // {funct7, funct3} of each legal OP instruction, indexed by its ALU code
   logic [9:0] legal_key [10] = '{
      {7'h00, 3'b000}, {7'h20, 3'b000}, {7'h00, 3'b001}, {7'h00, 3'b010}, {7'h00, 3'b011},
      {7'h00, 3'b100}, {7'h00, 3'b101}, {7'h20, 3'b101}, {7'h00, 3'b110}, {7'h00, 3'b111}
   };

   instr_fetch_decode #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_halt        (halt),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ack    (ack),
      .i_imem_rdata  (rdata),
      .o_rs1         (o_rs1),
      .o_rs2         (o_rs2),
      .o_rw          (o_rw),
      .o_operation   (o_operation),
      .o_write       (o_write),
      .o_busy        (o_busy),
      .o_illegal     (o_illegal),
      .o_instr_count (o_instr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running required finished");
      $fatal(1, "watchdog");
   end

   function automatic void ref_decode(input logic [31:0] ins, output logic [4:0] op, output bit ill);
      logic [9:0] key;
      key = {ins[31:25], ins[14:12]};
      op  = 5'd31;
      ill = 1'b1;
      if (ins[6:0] == 7'b0110011) begin
         for (int k = 0; k < 10; k++) begin
            if (key == legal_key[k]) begin
               op  = 5'(k);
               ill = 1'b0;
            end
         end
      end
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [9:0]  key;
      logic [31:0] ins;
      int          sel;
      sel = int'($urandom_range(0, 5));
      key = legal_key[$urandom_range(0, 9)];
      ins = {key[9:3], 5'($urandom), 5'($urandom), key[2:0], 5'($urandom), 7'b0110011};
      if (sel == 4) ins = $urandom;
      if (sel == 5) ins[31:25] = 7'($urandom_range(1, 127));
      return ins;
   endfunction

   task automatic model_reset();
      m_pc = RST_PC; m_count = 0; m_illegal = 0; m_busy = 0;
      m_rs1 = 0; m_rs2 = 0; m_rw = 0; m_op = 0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_pc   = RST_PC;
      m_busy = 1'b1;
      if (TRAP) m_illegal = 1'b0;
      checks++;
      if (o_imem_req !== 1'b1 || o_busy !== 1'b1 || o_imem_addr !== m_pc || o_illegal !== m_illegal) begin
         errors++;
         $display("FAIL start: got req=%0b busy=%0b addr=%h ill=%0b required req=1 busy=1 addr=%h ill=%0b",
                  o_imem_req, o_busy, o_imem_addr, o_illegal, m_pc, m_illegal);
      end
   endtask

   task automatic ensure_running();
      if (!m_busy) do_start();
   endtask

   // Expects to be entered on a negedge with the DUT waiting in FETCH
   task automatic run_instr(input logic [31:0] ins, input int delay, input bit spurious);
      logic [4:0] e_op;
      bit         e_ill;
      bit         e_wr;
      bit         trapped;
      ref_decode(ins, e_op, e_ill);
      e_wr = !e_ill && (ins[11:7] != 5'd0);

      checks++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== m_pc) begin
         errors++;
         $display("FAIL fetch_req: got req=%0b addr=%h required req=1 addr=%h", o_imem_req, o_imem_addr, m_pc);
      end
      for (int d = 0; d < delay; d++) begin
         ack = 1'b0;
         @(negedge clk);
         checks++;
         if (o_imem_req !== 1'b1 || o_imem_addr !== m_pc || o_write !== 1'b0) begin
            errors++;
            $display("FAIL fetch_hold: wait %0d got req=%0b addr=%h wr=%0b required req=1 addr=%h wr=0",
                     d, o_imem_req, o_imem_addr, o_write, m_pc);
         end
      end
      ack   = 1'b1;
      rdata = ins;
      @(negedge clk);
      // Decode cycle: an ack now must not overwrite the captured instruction
      ack   = spurious;
      rdata = $urandom;
      checks++;
      if (o_imem_req !== 1'b0 || o_write !== 1'b0 || o_busy !== 1'b1 ||
          {o_rs1, o_rs2, o_rw, o_operation} !== {m_rs1, m_rs2, m_rw, m_op}) begin
         errors++;
         $display("FAIL decode_hold: got req=%0b wr=%0b busy=%0b fields=%h required req=0 wr=0 busy=1 fields=%h",
                  o_imem_req, o_write, o_busy, {o_rs1, o_rs2, o_rw, o_operation}, {m_rs1, m_rs2, m_rw, m_op});
      end
      @(negedge clk);
      ack   = 1'b0;
      m_rs1 = ins[19:15];
      m_rs2 = ins[24:20];
      m_rw  = ins[11:7];
      m_op  = e_op;
      m_illegal = TRAP ? (m_illegal | e_ill) : e_ill;
      checks++;
      if ({o_rs1, o_rs2, o_rw, o_operation} !== {m_rs1, m_rs2, m_rw, m_op}) begin
         errors++;
         $display("FAIL exec_fields: got rs1=%0d rs2=%0d rw=%0d op=%0d required rs1=%0d rs2=%0d rw=%0d op=%0d",
                  o_rs1, o_rs2, o_rw, o_operation, m_rs1, m_rs2, m_rw, m_op);
      end
      checks++;
      if (o_write !== e_wr || o_illegal !== m_illegal || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL exec_write: got wr=%0b ill=%0b busy=%0b required wr=%0b ill=%0b busy=1",
                  o_write, o_illegal, o_busy, e_wr, m_illegal);
      end
      trapped = TRAP && e_ill;
      if (!e_ill) m_count = m_count + 32'd1;
      if (!trapped) m_pc = m_pc + 32'd4;
      m_busy = !(trapped || halt);
      @(negedge clk);
      checks++;
      if (o_write !== 1'b0 || o_instr_count !== m_count || o_illegal !== m_illegal) begin
         errors++;
         $display("FAIL retire: got wr=%0b count=%0d ill=%0b required wr=0 count=%0d ill=%0b",
                  o_write, o_instr_count, o_illegal, m_count, m_illegal);
      end
      checks++;
      if (o_busy !== m_busy || o_imem_req !== m_busy || o_imem_addr !== m_pc) begin
         errors++;
         $display("FAIL next_state: got busy=%0b req=%0b addr=%h required busy=%0b req=%0b addr=%h",
                  o_busy, o_imem_req, o_imem_addr, m_busy, m_busy, m_pc);
      end
      txn++;
      $display("txn %0d instr=%h wait=%0d op=%0d write=%0b illegal=%0b halt=%0b count=%0d next_pc=%h",
               txn, ins, delay, e_op, e_wr, e_ill, halt, m_count, m_pc);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (o_imem_req !== 1'b0 || o_write !== 1'b0 || o_busy !== 1'b0 || o_illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got req=%0b wr=%0b busy=%0b ill=%0b required all 0",
                  o_imem_req, o_write, o_busy, o_illegal);
      end
      checks++;
      if ({o_rs1, o_rs2, o_rw, o_operation} !== 20'h0 || o_instr_count !== 32'h0 || o_imem_addr !== RST_PC) begin
         errors++;
         $display("FAIL reset_data: got fields=%h count=%0d addr=%h required fields=0 count=0 addr=%h",
                  {o_rs1, o_rs2, o_rw, o_operation}, o_instr_count, o_imem_addr, RST_PC);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      do_start();
      run_instr(32'h002081B3, 0, 1'b0);
   endtask

   task automatic test_sub_wait();
      ensure_running();
      run_instr(32'h407302B3, 3, 1'b1);
   endtask

   task automatic test_illegal();
      ensure_running();
      run_instr(32'h00000013, 1, 1'b0);
   endtask

   task automatic test_x0_dest();
      ensure_running();
      run_instr(32'h00208033, 0, 1'b1);
   endtask

   task automatic test_halt();
      ensure_running();
      halt = 1'b1;
      run_instr(32'h0062F233, 2, 1'b0);
      for (int c = 0; c < 3; c++) begin
         ack = 1'b1;
         @(negedge clk);
         checks++;
         if (o_busy !== 1'b0 || o_imem_req !== 1'b0 || o_instr_count !== m_count) begin
            errors++;
            $display("FAIL halt_idle: got busy=%0b req=%0b count=%0d required busy=0 req=0 count=%0d",
                     o_busy, o_imem_req, o_instr_count, m_count);
         end
      end
      ack  = 1'b0;
      halt = 1'b0;
      do_start();
      run_instr(32'h40D65533, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         ensure_running();
         halt = ($urandom_range(0, 7) == 0);
         run_instr(gen_instr(), int'($urandom_range(0, 3)), 1'($urandom));
         halt = 1'b0;
      end
   endtask

   task automatic test_async_reset();
      ensure_running();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (o_imem_req !== 1'b0 || o_write !== 1'b0 || o_busy !== 1'b0 || o_illegal !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_ctrl: got req=%0b wr=%0b busy=%0b ill=%0b required all 0",
                  o_imem_req, o_write, o_busy, o_illegal);
      end
      checks++;
      if ({o_rs1, o_rs2, o_rw, o_operation} !== 20'h0 || o_instr_count !== 32'h0 || o_imem_addr !== RST_PC) begin
         errors++;
         $display("FAIL async_reset_data: got fields=%h count=%0d addr=%h required fields=0 count=0 addr=%h",
                  {o_rs1, o_rs2, o_rw, o_operation}, o_instr_count, o_imem_addr, RST_PC);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_start();
      run_instr(32'h00B50633, 1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_wait();
      test_illegal();
      test_x0_dest();
      test_halt();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Upstream stage of the processor datapath: fetches 32-bit RV32I instructions from instruction memory and decodes R-type ALU instructions.
- Drives the datapath's register-select fields (rs1, rs2, rw), ALU operation code and register write strobe.
- Runs a multi-cycle fetch/decode/execute FSM with a program counter and a req/ack memory handshake.
- Only OP (0110011) instructions are legal; everything else is flagged illegal.

Parameters:
- ADDR_WIDTH, 32, width of program counter and imem_addr.
- RESET_PC, 0, PC value loaded on reset and on start.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  in IDLE: load RESET_PC and begin fetching; ignored elsewhere.
- halt  in  1  finish current instruction, then return to IDLE.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_WIDTH  fetch address (= pc).
- imem_ack  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- rs1  out  5  source register 1 index.
- rs2  out  5  source register 2 index.
- rw  out  5  destination register index.
- operation  out  5  ALU operation code.
- write  out  1  register file write strobe.
- busy  out  1  FSM not in IDLE.
- illegal  out  1  last decoded instruction was illegal.
- instr_count  out  32  count of retired legal instructions.

Behaviour:
- Reset values: FSM=IDLE, pc=RESET_PC, IR=0, imem_req=0, rs1/rs2/rw/operation=0, write=0, busy=0, illegal=0, instr_count=0.
- Reset is asynchronous; asserting it mid-operation drops imem_req and write immediately and discards any in-flight fetch.
- FSM states: IDLE, FETCH, DECODE, EXEC.
- IDLE -> FETCH on start. pc is loaded with RESET_PC.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - imem_rdata is sampled into IR only on a cycle with imem_req && imem_ack.
  - Then -> DECODE.
  - Ack while imem_req=0 is ignored.
- DECODE:
  - Fields are registered from IR: rs1=IR[19:15], rs2=IR[24:20], rw=IR[11:7].
  - Operation is mapped from {funct7, funct3}.
  - illegal is updated. Next state is EXEC.
- EXEC:
  - write=1 for exactly one cycle if the instruction is legal and rw!=0; otherwise write=0.
  - rs1/rs2/rw/operation remain stable from DECODE through EXEC and hold until the next DECODE.
  - On legal retire: instr_count += 1 (wraps at 2^32-1 to 0).
  - pc += 4, modulo 2^ADDR_WIDTH.
  - Next state: IDLE if halt is sampled high in EXEC, else FETCH.
- halt has no effect in IDLE. halt raised during FETCH or DECODE takes effect only if still high in EXEC.
- Latency: ack in cycle N -> decoded fields valid in N+2 -> write pulse in N+2 -> next imem_req in N+3. Minimum 3 cycles per instruction with zero-wait memory.
- Legal encodings (opcode 0110011, funct7 0000000 or 0100000):
  - ADD 000/00
  - SUB 000/20
  - SLL 001/00
  - SLT 010/00
  - SLTU 011/00
  - XOR 100/00
  - SRL 101/00
  - SRA 101/20
  - OR 110/00
  - AND 111/00
- Any other combination is illegal: operation=OP_NOP and write=0.
- busy=1 in FETCH/DECODE/EXEC.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal instruction makes EXEC go to IDLE regardless of halt, with pc not advanced.
  - illegal stays sticky at 1 until the next start or reset.
- Undefined:
  - Illegal instructions act as NOPs: pc advances, no count increment.
  - illegal reflects only the most recent decode.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constant OPC_OP=7'b0110011;
  - funct7 constants F7_BASE=0x00, F7_ALT=0x20;
  - the 5-bit ALU operation codes OP_ADD=0, OP_SUB=1, OP_SLL=2, OP_SLT=3, OP_SLTU=4, OP_XOR=5, OP_SRL=6, OP_SRA=7, OP_OR=8, OP_AND=9, OP_NOP=31;
  - the FSM state encoding.
- These operation codes are the same codes the ALU consumes.
- One natural sub-module: alu_op_decoder, combinational, mapping {funct7, funct3, opcode} to {operation, illegal}.

Test Plan:
- Reset low, then start with zero-wait ack returning 0x002081B3 (ADD x3,x1,x2):
  - imem_addr=0;
  - rs1=1, rs2=2, rw=3, operation=0;
  - write pulses exactly 1 cycle;
  - next fetch addr=4; instr_count=1.
- Return 0x407302B3 (SUB x5,x6,x7) with ack delayed 3 cycles:
  - imem_req and imem_addr held stable for all 4 cycles;
  - operation=1, rw=5, single write pulse.
- Return 0x00000013 (ADDI):
  - illegal=1, write=0, instr_count unchanged;
  - with DECODE_ILLEGAL_TRAP_EN: FSM in IDLE, busy=0, pc unchanged;
  - without: fetch continues at pc+4.
- Return 0x00208033 (ADD x0,x1,x2): write=0, instr_count still increments.
- Assert halt during FETCH and hold it: current instruction completes, then busy=0; a later start refetches from RESET_PC.
- Drop reset mid-FETCH (asynchronously, between clock edges): imem_req=0 immediately and all outputs return to reset values before the next edge.
